// File: rtl/sram_access_arbiter_if.sv
// Request/response and SSRAM pin bundle for the SSRAM access arbiter.
// The slave side is the arbiter; the master side is requesters plus SSRAM.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic              WR_REQ;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_ACK;
    logic              RD_REQ;
    logic [ADDR_W-1:0] RD_ADDR;
    logic              RD_ACK;
    logic              RD_URGENT;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic [ADDR_W-1:0] SRAM_ADDRESS;
    logic [DATA_W-1:0] SRAM_DQ_OUT;
    logic              SRAM_DQ_OE;
    logic [DATA_W-1:0] SRAM_DQ_IN;
    logic              SRAM_ADSC_N;
    logic              SRAM_ADSP_N;
    logic              SRAM_WE_N;
    logic              SRAM_OE_N;

    modport slave (
        input  WR_REQ, WR_ADDR, WR_DATA,
        input  RD_REQ, RD_ADDR, RD_URGENT,
        input  SRAM_DQ_IN,
        output WR_ACK, RD_ACK, RD_DATA, RD_VALID,
        output SRAM_ADDRESS, SRAM_DQ_OUT, SRAM_DQ_OE,
        output SRAM_ADSC_N, SRAM_ADSP_N, SRAM_WE_N, SRAM_OE_N
    );

    modport master (
        output WR_REQ, WR_ADDR, WR_DATA,
        output RD_REQ, RD_ADDR, RD_URGENT,
        output SRAM_DQ_IN,
        input  WR_ACK, RD_ACK, RD_DATA, RD_VALID,
        input  SRAM_ADDRESS, SRAM_DQ_OUT, SRAM_DQ_OE,
        input  SRAM_ADSC_N, SRAM_ADSP_N, SRAM_WE_N, SRAM_OE_N
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares one synchronous SSRAM between a pixel write port and a display read port.
// Burst-limited round-robin with read-urgency override and write anti-starvation.
module sram_access_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    sram_access_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, WR_CYC, RD_ADDR, RD_WAIT, RD_LATCH
    } state_t;

    localparam logic [3:0] MAX_B    = 4'(MAX_BURST);
    localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              last_q, last_d;
    logic [3:0]        burst_q, burst_d;
    logic [3:0]        starve_q, starve_d;
    logic              adsc_n_q, adsc_n_d;
    logic              adsp_n_q, adsp_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              dp, both, gnt_wr, gnt_rd;

    // last_q: 0 = write port owned the previous grant, 1 = read port
    always_comb begin
        dp     = state_q inside {IDLE, WR_CYC, RD_LATCH};
        both   = bus.WR_REQ && bus.RD_REQ;
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (dp) begin
            if (!both) begin
                gnt_wr = bus.WR_REQ;
                gnt_rd = bus.RD_REQ;
            end else if (starve_q >= STARVE_L) begin
                gnt_wr = 1'b1;
            end else if (bus.RD_URGENT) begin
                gnt_rd = 1'b1;
            end else if (burst_q < MAX_B) begin
                gnt_wr = !last_q;
                gnt_rd = last_q;
            end else begin
                gnt_wr = last_q;
                gnt_rd = !last_q;
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        last_d     = last_q;
        burst_d    = burst_q;
        starve_d   = starve_q;

        case (state_q)
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RD_LATCH;
            default: state_d = IDLE;
        endcase

        if (state_q == RD_LATCH) begin
            rd_data_d  = bus.SRAM_DQ_IN;
            rd_valid_d = 1'b1;
        end

        if (gnt_wr) begin
            state_d = WR_CYC;
            addr_d  = bus.WR_ADDR;
            data_d  = bus.WR_DATA;
        end
        if (gnt_rd) begin
            state_d = RD_ADDR;
            addr_d  = bus.RD_ADDR;
        end

        if (gnt_wr || gnt_rd) begin
            if (gnt_rd == last_q) begin
                burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
            end else begin
                last_d  = gnt_rd;
                burst_d = 4'd1;
            end
        end

        if (dp) begin
            if (gnt_wr || !bus.WR_REQ)
                starve_d = 4'd0;
            else if (starve_q != 4'hF)
                starve_d = starve_q + 4'd1;
        end

        // Strobes are registered, so they are decoded from the state being entered
        adsc_n_d = state_d != WR_CYC;
        we_n_d   = state_d != WR_CYC;
        dq_oe_d  = state_d == WR_CYC;
        adsp_n_d = state_d != RD_ADDR;
        oe_n_d   = !(state_d == RD_WAIT || state_d == RD_LATCH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            last_q     <= 1'b0;
            burst_q    <= 4'd0;
            starve_q   <= 4'd0;
            adsc_n_q   <= 1'b1;
            adsp_n_q   <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            starve_q   <= starve_d;
            adsc_n_q   <= adsc_n_d;
            adsp_n_q   <= adsp_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign bus.WR_ACK       = gnt_wr;
    assign bus.RD_ACK       = gnt_rd;
    assign bus.RD_DATA      = rd_data_q;
    assign bus.RD_VALID     = rd_valid_q;
    assign bus.SRAM_ADDRESS = addr_q;
    assign bus.SRAM_DQ_OUT  = data_q;
    assign bus.SRAM_DQ_OE   = dq_oe_q;
    assign bus.SRAM_ADSC_N  = adsc_n_q;
    assign bus.SRAM_ADSP_N  = adsp_n_q;
    assign bus.SRAM_WE_N    = we_n_q;
    assign bus.SRAM_OE_N    = oe_n_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a small pipelined SSRAM model.
// Table of per-cycle vectors plus hand sequences for latency, starvation, reset.
module tb_sram_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    sram_access_arbiter_if bus ();

    sram_access_arbiter dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pipelined SSRAM: address sampled on ADSP_N, data on DQ two edges later
    logic [31:0] mem [logic [18:0]];
    logic [31:0] pipe1 = 32'h0;
    initial bus.SRAM_DQ_IN = 32'h0;

    always @(posedge clk) begin
        if (!bus.SRAM_ADSC_N && !bus.SRAM_WE_N)
            mem[bus.SRAM_ADDRESS] = bus.SRAM_DQ_OUT;
        if (!bus.SRAM_ADSP_N)
            pipe1 <= mem.exists(bus.SRAM_ADDRESS) ? mem[bus.SRAM_ADDRESS] : 32'h0;
        bus.SRAM_DQ_IN <= pipe1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if (bus.WR_ACK && bus.RD_ACK) begin
                n_fail++;
                $display("FAIL ack_excl: got both acks expected at most one");
            end
            n_chk++;
            if (bus.SRAM_DQ_OE && !bus.SRAM_OE_N) begin
                n_fail++;
                $display("FAIL turnaround: got DQ_OE=1 with OE_N=0 expected exclusive");
            end
        end
    end

    typedef struct packed {
        logic wr, rd, urg;
        logic wack, rack;
        logic adsc_n, adsp_n, oe_n, dq_oe, rv;
    } vec_t;

    vec_t tv [20];

    task automatic idle_inputs();
        bus.WR_REQ    = 1'b0;
        bus.WR_ADDR   = '0;
        bus.WR_DATA   = '0;
        bus.RD_REQ    = 1'b0;
        bus.RD_ADDR   = '0;
        bus.RD_URGENT = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        bit   found;
        bit   bad;
        int   got;
        int   cyc;
        logic [31:0] rdat;

        // Both requesting, no urgency: W x4, then R x4, then W
        tv[0]  = 10'b110_10_11100;
        tv[1]  = 10'b110_10_01110;
        tv[2]  = 10'b110_10_01110;
        tv[3]  = 10'b110_10_01110;
        tv[4]  = 10'b110_01_01110;
        tv[5]  = 10'b110_00_10100;
        tv[6]  = 10'b110_00_11000;
        tv[7]  = 10'b110_01_11000;
        tv[8]  = 10'b110_00_10101;
        tv[9]  = 10'b110_00_11000;
        tv[10] = 10'b110_01_11000;
        tv[11] = 10'b110_00_10101;
        tv[12] = 10'b110_00_11000;
        tv[13] = 10'b110_01_11000;
        tv[14] = 10'b110_00_10101;
        tv[15] = 10'b110_00_11000;
        tv[16] = 10'b110_10_11000;
        tv[17] = 10'b110_10_01111;
        tv[18] = 10'b000_00_01110;
        tv[19] = 10'b000_00_11100;

        do_reset();
        mon_en = 1'b1;

        @(negedge clk);
        chk("rst adsc_n", bus.SRAM_ADSC_N, 1);
        chk("rst adsp_n", bus.SRAM_ADSP_N, 1);
        chk("rst we_n", bus.SRAM_WE_N, 1);
        chk("rst oe_n", bus.SRAM_OE_N, 1);
        chk("rst dq_oe", bus.SRAM_DQ_OE, 0);
        chk("rst addr", bus.SRAM_ADDRESS, 0);
        chk("rst dq_out", bus.SRAM_DQ_OUT, 0);
        chk("rst rd_data", bus.RD_DATA, 0);
        chk("rst rd_valid", bus.RD_VALID, 0);
        @(posedge clk);
        #1;

        // Single write from IDLE
        bus.WR_REQ  = 1'b1;
        bus.WR_ADDR = 19'h00010;
        bus.WR_DATA = 32'h3FF003FF;
        @(negedge clk);
        chk("w1 wr_ack", bus.WR_ACK, 1);
        chk("w1 rd_ack", bus.RD_ACK, 0);
        @(posedge clk);
        #1 bus.WR_REQ = 1'b0;
        @(negedge clk);
        chk("w1 adsc_n", bus.SRAM_ADSC_N, 0);
        chk("w1 we_n", bus.SRAM_WE_N, 0);
        chk("w1 dq_oe", bus.SRAM_DQ_OE, 1);
        chk("w1 addr", bus.SRAM_ADDRESS, 19'h00010);
        chk("w1 dq_out", bus.SRAM_DQ_OUT, 32'h3FF003FF);
        @(posedge clk);
        #1;

        // Write then read back-to-back, check read latency and data
        bus.WR_REQ  = 1'b1;
        bus.WR_ADDR = 19'h5DBFF;
        bus.WR_DATA = 32'h12345678;
        @(negedge clk);
        chk("w2 wr_ack", bus.WR_ACK, 1);
        @(posedge clk);
        #1;
        bus.WR_REQ  = 1'b0;
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 19'h5DBFF;
        @(negedge clk);
        chk("r2 rd_ack", bus.RD_ACK, 1);
        @(posedge clk);
        #1 bus.RD_REQ = 1'b0;
        lat   = 0;
        found = 1'b0;
        rdat  = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.RD_VALID && !found) begin
                found = 1'b1;
                lat   = k;
                rdat  = bus.RD_DATA;
            end
        end
        chk("r2 latency", 64'(lat), 4);
        chk("r2 rd_data", rdat, 32'h12345678);
        @(posedge clk);
        #1;

        // Table: both requesting, round-robin bursts
        do_reset();
        bus.WR_ADDR = 19'h00123;
        bus.WR_DATA = 32'hA5A5A5A5;
        bus.RD_ADDR = 19'h00456;
        for (int i = 0; i < 20; i++) begin
            bus.WR_REQ    = tv[i].wr;
            bus.RD_REQ    = tv[i].rd;
            bus.RD_URGENT = tv[i].urg;
            @(negedge clk);
            chk($sformatf("tv%0d wr_ack", i), bus.WR_ACK, tv[i].wack);
            chk($sformatf("tv%0d rd_ack", i), bus.RD_ACK, tv[i].rack);
            chk($sformatf("tv%0d adsc_n", i), bus.SRAM_ADSC_N, tv[i].adsc_n);
            chk($sformatf("tv%0d we_n", i), bus.SRAM_WE_N, tv[i].adsc_n);
            chk($sformatf("tv%0d adsp_n", i), bus.SRAM_ADSP_N, tv[i].adsp_n);
            chk($sformatf("tv%0d oe_n", i), bus.SRAM_OE_N, tv[i].oe_n);
            chk($sformatf("tv%0d dq_oe", i), bus.SRAM_DQ_OE, tv[i].dq_oe);
            chk($sformatf("tv%0d rd_valid", i), bus.RD_VALID, tv[i].rv);
            @(posedge clk);
            #1;
        end

        // Urgent reads starve the writer until the forced grant
        do_reset();
        bus.WR_REQ    = 1'b1;
        bus.RD_REQ    = 1'b1;
        bus.RD_URGENT = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 18 && cyc < 120) begin
            @(negedge clk);
            if (bus.WR_ACK || bus.RD_ACK) begin
                chk($sformatf("urg grant%0d is_write", got), bus.WR_ACK,
                    (got == 8 || got == 17) ? 1 : 0);
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("urg grants seen", 64'(got), 18);
        idle_inputs();

        // Reset during RD_WAIT aborts the read
        do_reset();
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 19'h00005;
        @(negedge clk);
        chk("ab rd_ack", bus.RD_ACK, 1);
        @(posedge clk);
        #1 bus.RD_REQ = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ab adsc_n", bus.SRAM_ADSC_N, 1);
        chk("ab adsp_n", bus.SRAM_ADSP_N, 1);
        chk("ab we_n", bus.SRAM_WE_N, 1);
        chk("ab oe_n", bus.SRAM_OE_N, 1);
        chk("ab dq_oe", bus.SRAM_DQ_OE, 0);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.RD_VALID !== 1'b0)
                bad = 1'b1;
        end
        chk("ab no rd_valid", bad, 0);
        @(posedge clk);
        #1 bus.RD_REQ = 1'b1;
        @(negedge clk);
        chk("ab next rd_ack", bus.RD_ACK, 1);
        @(posedge clk);
        #1 bus.RD_REQ = 1'b0;
        @(negedge clk);
        chk("ab next adsp_n", bus.SRAM_ADSP_N, 0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Shares the single synchronous SSRAM on the DE2-70 between two requesters: a write port (CCD/processed-pixel store path) and a read port (display fetch path). It sequences SSRAM command cycles: a single-cycle write, and a three-cycle pipelined read of ADSP, wait, latch. Arbitration is burst-limited round-robin with a display-urgency override and a write anti-starvation limit. It replaces the hard-wired store/fetch sequencing inside the frame-buffer controller. The fixed SSRAM pins (ADV_N, BE_N, CE*, GW_N, CLK) stay at top level.

Parameters:
ADDR_W, 19, SSRAM word address width
DATA_W, 32, SSRAM data width
MAX_BURST, 4, consecutive grants to one owner before yielding when both request (range 1..15)
STARVE_LIMIT, 8, decision points a pending write may lose before forced grant (range 1..15)

Ports:
CLK  in  1  system clock; the SSRAM clock is the same net
RESET  in  1  synchronous, active-high reset
WR_REQ  in  1  write valid; WR_ADDR and WR_DATA are stable while high
WR_ADDR  in  ADDR_W  write address
WR_DATA  in  DATA_W  write data
WR_ACK  out  1  write ready; transfer occurs on the edge where WR_REQ&&WR_ACK
RD_REQ  in  1  read valid; RD_ADDR is stable while high
RD_ADDR  in  ADDR_W  read address
RD_ACK  out  1  read ready; transfer occurs on the edge where RD_REQ&&RD_ACK
RD_URGENT  in  1  display FIFO low; the read wins arbitration
RD_DATA  out  DATA_W  read data, registered
RD_VALID  out  1  one-cycle strobe qualifying RD_DATA
SRAM_ADDRESS  out  ADDR_W  registered SSRAM address
SRAM_DQ_OUT  out  DATA_W  registered write data
SRAM_DQ_OE  out  1  registered; top level drives the DQ bus only when high
SRAM_DQ_IN  in  DATA_W  DQ bus readback
SRAM_ADSC_N, SRAM_ADSP_N, SRAM_WE_N, SRAM_OE_N  out  1 each  registered SSRAM strobes

Behaviour:
- Reset applies on any CLK edge with RESET=1 and aborts any transaction in flight; no RD_VALID is issued for an aborted read.
- Reset values: state IDLE; all *_N outputs 1; SRAM_DQ_OE=0; SRAM_ADDRESS=0; SRAM_DQ_OUT=0; RD_DATA=0; RD_VALID=0; LAST=write; BURST_CNT=0; STARVE_CNT=0.
- States: IDLE, WR_CYC, RD_ADDR, RD_WAIT, RD_LATCH.
- Decision points are IDLE, WR_CYC and RD_LATCH. WR_ACK and RD_ACK are combinational from state and requests, are high only at a decision point, and are never high together. Neither ACK depends combinationally on itself.
- Grant rules at a decision point:
  - Only one requester active: grant it.
  - Both active, STARVE_CNT>=STARVE_LIMIT: grant write.
  - Both active, otherwise RD_URGENT=1: grant read.
  - Both active, otherwise BURST_CNT<MAX_BURST: grant LAST.
  - Both active, otherwise: grant the other owner.
  - Neither active: next state IDLE, no grant.
- Write grant: latch WR_ADDR and WR_DATA; next state WR_CYC. In WR_CYC: ADSC_N=0, WE_N=0, DQ_OE=1, address and data driven from the latches.
- Read grant: latch RD_ADDR; next state RD_ADDR. Then:
  - RD_ADDR: ADSP_N=0.
  - RD_WAIT: OE_N=0.
  - RD_LATCH: OE_N=0; RD_DATA<=SRAM_DQ_IN at the end of the cycle.
  - RD_VALID=1 in the following cycle only.
- Latency: read handshake edge E gives RD_VALID in cycle E+4. Peak read rate is one per 3 cycles; peak write rate is one per cycle.
- Owner tracking: a grant to the same owner as LAST sets BURST_CNT=min(BURST_CNT+1,15). A grant to the other owner sets LAST to it and BURST_CNT=1. Urgent and forced grants count normally.
- STARVE_CNT: increments (saturating at 15) at each decision point where WR_REQ=1 and read is granted. It clears on a write grant, or at any decision point where WR_REQ=0.
- Bus turnaround: DQ_OE is 0 in every non-write state. Read-after-write and write-after-read need no idle cycle, because OE_N is asserted only in RD_WAIT and RD_LATCH.
- Requests or address changes outside decision points are ignored; only the value present at a handshake edge is used.

Test Plan:
- Reset then WR_REQ=1 alone, WR_ADDR=0x00010, WR_DATA=0x3FF003FF -> WR_ACK high in IDLE. Next cycle: ADSC_N=0, WE_N=0, DQ_OE=1, SRAM_ADDRESS=0x00010, DQ_OUT=0x3FF003FF.
- Write 0x12345678 to 0x5DBFF, then RD_REQ alone for 0x5DBFF with the SRAM model -> RD_VALID exactly 4 cycles after the RD handshake edge; RD_DATA=0x12345678.
- WR_REQ and RD_REQ both held, RD_URGENT=0, MAX_BURST=4 -> grant sequence W,W,W,W,R,R,R,R,W...; never both ACKs in one cycle.
- Both held, RD_URGENT=1 constantly, STARVE_LIMIT=8 -> 8 read grants, then 1 forced write grant, then reads resume with STARVE_CNT=0.
- RESET pulsed during RD_WAIT -> RD_VALID stays 0; all *_N=1 and DQ_OE=0 the cycle after reset; the next request is served from IDLE.
- Write immediately followed by read -> DQ_OE=0 in every cycle where OE_N=0; SRAM_DQ_OE and SRAM_OE_N are never active together.
